// File: rtl/led_seq_pkg.sv
// Shared constants for the LED pattern sequencer: register map, bit positions
// and the sequencer FSM state encoding.
package led_seq_pkg;

    localparam int LED_W = 4;
    localparam int DEPTH = 4;
    localparam int IDX_W = 2;

    localparam logic [2:0] CTRL_ADDR   = 3'd0;
    localparam logic [2:0] PERIOD_ADDR = 3'd1;
    localparam logic [2:0] STATUS_ADDR = 3'd2;
    localparam logic [2:0] PAT_BASE    = 3'd4;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_ONESHOT_BIT = 1;
    localparam int CTRL_LAST_LSB    = 4;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_IDX_LSB  = 4;
    localparam int STAT_DONE_BIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT,
        ST_BLANK
    } seq_state_e;

endpackage

// File: rtl/led_pattern_sequencer.sv
// Avalon-MM master that steps the LED PIO through a host-loaded pattern table
// at a programmable period, looping or one-shot.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        busy
);

    logic                enable;
    logic                oneshot;
    logic                done;
    logic [IDX_W-1:0]    last_idx;
    logic [PERIOD_W-1:0] period;
    logic [LED_W-1:0]    pat [DEPTH];

    seq_state_e          state, state_nxt;
    logic [IDX_W-1:0]    cur_idx, cur_idx_nxt;
    logic [PERIOD_W-1:0] cnt, cnt_nxt;
    logic                advance;
    logic                finish;

    logic cfg_wr;
    logic enable_host;
    logic unused_wdata;

    assign cfg_wr       = cfg_chipselect && !cfg_write_n;
    assign unused_wdata = ^cfg_writedata[31:PERIOD_W];

    // Enable as the host will have left it after this edge, so a start or a
    // stop acts on the very edge of the CTRL write.
    assign enable_host = (cfg_wr && cfg_address == CTRL_ADDR)
                       ? cfg_writedata[CTRL_EN_BIT] : enable;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cur_idx <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            cur_idx <= cur_idx_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt   = state;
        cur_idx_nxt = cur_idx;
        cnt_nxt     = cnt;
        advance     = 1'b0;
        finish      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable_host) begin
                    state_nxt   = ST_STROBE;
                    cur_idx_nxt = '0;
                end
            end
            ST_STROBE: begin
                if (!enable_host) begin
                    state_nxt = ST_BLANK;
                end else if (period <= PERIOD_W'(1)) begin
                    advance = 1'b1;
                end else begin
                    cnt_nxt   = period - 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable_host) begin
                    state_nxt = ST_BLANK;
                end else if (cnt <= PERIOD_W'(1)) begin
                    advance = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_BLANK: begin
                state_nxt   = ST_IDLE;
                cur_idx_nxt = '0;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (advance) begin
            if (cur_idx != last_idx) begin
                cur_idx_nxt = cur_idx + 1'b1;
                state_nxt   = ST_STROBE;
            end else if (!oneshot) begin
                cur_idx_nxt = '0;
                state_nxt   = ST_STROBE;
            end else begin
                finish    = 1'b1;
                state_nxt = ST_IDLE;
            end
        end
    end

    always_comb begin
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_writedata  = '0;
        case (state)
            ST_STROBE: begin
                pio_chipselect             = 1'b1;
                pio_write_n                = 1'b0;
                pio_writedata[LED_W-1:0]   = pat[cur_idx];
            end
            ST_BLANK: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
            end
            default: ;
        endcase
    end

    assign pio_address = 2'd0;
    assign busy        = (state != ST_IDLE);

    // NOTE: the pattern table is a handful of flops and must read 0 after
    // reset, so it is reset like any other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            oneshot  <= 1'b0;
            last_idx <= '0;
            period   <= '0;
            done     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) pat[i] <= '0;
        end else begin
            if (cfg_wr) begin
                case (cfg_address)
                    CTRL_ADDR: begin
                        enable   <= cfg_writedata[CTRL_EN_BIT];
                        oneshot  <= cfg_writedata[CTRL_ONESHOT_BIT];
                        last_idx <= cfg_writedata[CTRL_LAST_LSB +: IDX_W];
                    end
                    PERIOD_ADDR: period <= cfg_writedata[PERIOD_W-1:0];
                    STATUS_ADDR: if (cfg_writedata[STAT_DONE_BIT]) done <= 1'b0;
                    default: begin
                        if (cfg_address >= PAT_BASE)
                            pat[cfg_address[IDX_W-1:0]] <= cfg_writedata[LED_W-1:0];
                    end
                endcase
            end
            // Completion overrides a same-cycle host clear of done.
            if (finish) begin
                done   <= 1'b1;
                enable <= 1'b0;
            end
        end
    end

    always_comb begin
        cfg_readdata = '0;
        case (cfg_address)
            CTRL_ADDR: begin
                cfg_readdata[CTRL_EN_BIT]                 = enable;
                cfg_readdata[CTRL_ONESHOT_BIT]            = oneshot;
                cfg_readdata[CTRL_LAST_LSB +: IDX_W]      = last_idx;
            end
            PERIOD_ADDR: cfg_readdata[PERIOD_W-1:0] = period;
            STATUS_ADDR: begin
                cfg_readdata[STAT_BUSY_BIT]               = busy;
                cfg_readdata[STAT_IDX_LSB +: IDX_W]       = cur_idx;
                cfg_readdata[STAT_DONE_BIT]               = done;
            end
            default: begin
                if (cfg_address >= PAT_BASE)
                    cfg_readdata[LED_W-1:0] = pat[cfg_address[IDX_W-1:0]];
            end
        endcase
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Avalon-MM controller that sequences the 4-bit LED PIO peripheral.
- Host software loads up to 4 patterns and a step period through a config slave port, then sets enable.
- The block drives the PIO slave port (address/chipselect/write_n/writedata) as a master, writing patterns in order, looping or one-shot.
- Sits between the PCIe BAR-mapped Avalon fabric (config side) and the LED PIO (master side); it is the PIO's only writer.

Parameters:
PERIOD_W, 24, width of step-period register and countdown counter
LED_W, 4, pattern width; matches PIO data_out width
DEPTH, 4, pattern table entries (index width 2)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
cfg_address  in  3  config register word address
cfg_chipselect  in  1  config slave select
cfg_write_n  in  1  config write strobe, active-low
cfg_writedata  in  32  config write data
cfg_readdata  out  32  config read data, combinational, zero wait states
pio_address  out  2  PIO address; always 0
pio_chipselect  out  1  PIO select; single-cycle pulse per write
pio_write_n  out  1  PIO write strobe, active-low; low only with pio_chipselect
pio_writedata  out  32  PIO write data; bits [LED_W-1:0] = pattern, rest 0
busy  out  1  high while FSM not IDLE

Behaviour:
- Register map (cfg_address):
  - 0 CTRL: bit0 enable, bit1 oneshot, bits[5:4] last_idx.
  - 1 PERIOD: [PERIOD_W-1:0].
  - 2 STATUS: bit0 busy (RO), bits[5:4] cur_idx (RO), bit8 done (sticky, write-1-to-clear).
  - 4..7 PAT0..PAT3: [3:0].
  - Unmapped reads return 0; unmapped writes are ignored.
- Writes take effect when cfg_chipselect && !cfg_write_n at the clock edge. Readdata is zero-extended.
- Reset values: all registers 0, cur_idx 0, FSM IDLE, pio_chipselect 0, pio_write_n 1, pio_writedata 0, pio_address 0, busy 0, cfg_readdata per register values.
- FSM states: IDLE, STROBE, WAIT, BLANK.
  - IDLE: if enable=1, go to STROBE with cur_idx=0.
  - STROBE:
    - For exactly one cycle: pio_chipselect=1, pio_write_n=0, pio_writedata=PAT[cur_idx].
    - Load cnt=PERIOD.
    - If PERIOD=0, advance immediately (next state per advance rule); else go to WAIT.
  - WAIT: cnt decrements each cycle. When cnt reaches 1, apply the advance rule.
  - Advance rule:
    - If cur_idx != last_idx: cur_idx+1, go to STROBE.
    - Else if oneshot=0: cur_idx=0, go to STROBE.
    - Else: set done=1, clear enable, go to IDLE. LEDs keep the last pattern.
  - BLANK:
    - One cycle: strobe write of 0 to the PIO.
    - Then go to IDLE with cur_idx=0.
- Timing: consecutive STROBE cycles are exactly PERIOD cycles apart, with PERIOD=0 treated as 1, i.e. back-to-back. First strobe occurs in the cycle after the enable write edge.
- Enable cleared by host in STROBE or WAIT: the next state is BLANK (pending advance is discarded). Enable cleared while IDLE has no effect.
- Simultaneous done set (final advance) and host write-1-to-clear of done in the same cycle: set wins.
- Host writes to PAT/PERIOD/last_idx while running:
  - PAT and last_idx are sampled at the next STROBE or advance decision.
  - PERIOD is sampled only at the next STROBE; the current countdown is unaffected.
- last_idx may exceed entries the host has loaded; unloaded entries hold 0 (LEDs off).
- Enable write of 1 while already running: no restart, no effect.
- Reset mid-operation: immediate return to reset values. The PIO has its own reset, so no BLANK write is issued.

Decomposition:
- Package led_seq_pkg holds:
  - register offsets (CTRL=0, PERIOD=1, STATUS=2, PAT_BASE=4);
  - CTRL/STATUS bit positions;
  - FSM state enum;
  - the LED_W/DEPTH constants.
- Single module; no sub-module needed (the countdown counter is inline).

Test Plan:
- Reset: assert reset_n=0 mid-WAIT → pio_chipselect=0, pio_write_n=1, busy=0, all cfg_readdata reads 0 after release.
- Loop: PAT0..3 = 1,2,4,8, PERIOD=5, last_idx=3, oneshot=0, enable=1 → strobes every 5 cycles with data 1,2,4,8,1,2…; pio_address always 0; STATUS.cur_idx tracks.
- One-shot: same config with oneshot=1, last_idx=2 → three strobes (1,2,4), then IDLE, done=1, CTRL.enable reads 0; write 0x100 to STATUS → done=0.
- PERIOD=0: last_idx=1, PAT0=0xA, PAT1=0x5 → strobes on every cycle alternating 0xA/0x5.
- Disable mid-run: clear enable during WAIT at cur_idx=2 → next cycle a strobe with data 0 (BLANK), then IDLE, busy=0, cur_idx=0.
- Live update: change PAT1 from 2 to 0xF during WAIT of idx 0, and PERIOD from 5 to 3 → next strobe carries 0xF after the original 5-cycle gap; the following gap is 3 cycles.
